// File: rtl/div_pkg.sv
// Shared definitions for the division request sequencer: FSM encoding,
// default timeout and the timeout-counter width helper.
package div_pkg;

  localparam int DIV_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } div_state_e;

  // The counter must be able to hold TIMEOUT_CYCLES itself without wrapping.
  function automatic int timer_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/div_request_sequencer_if.sv
// Job, result and divider-side signals of the request sequencer.
// The slave modport is the sequencer; master is the surrounding system.
interface div_request_sequencer_if #(
  parameter int BITS = 16
) ();

  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_dividend;
  logic [BITS-1:0] in_divisor;

  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_quotient;
  logic            out_error;
  logic            out_timeout;

  logic [BITS-1:0] div_dividend;
  logic [BITS-1:0] div_divisor;
  logic            div_reset;
  logic            div_ready;
  logic [BITS-1:0] div_result;

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready, div_ready, div_result,
    output in_ready, out_valid, out_quotient, out_error, out_timeout,
           div_dividend, div_divisor, div_reset
  );

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready, div_ready, div_result,
    input  in_ready, out_valid, out_quotient, out_error, out_timeout,
           div_dividend, div_divisor, div_reset
  );

endinterface

// File: rtl/div_request_sequencer_timer.sv
// RUN-cycle counter: cleared outside RUN, saturates at TIMEOUT_CYCLES and
// flags the cycle in which the last permitted RUN cycle completes.
module div_request_sequencer_timer
  import div_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DIV_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int            CW   = timer_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CAP  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CAP)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = inc_i && (count_q == LAST);

endmodule

// File: rtl/div_request_sequencer.sv
// Sequences one division job at a time through an external SAR divider,
// bypassing it for zero operands and abandoning it after a RUN timeout.
module div_request_sequencer
  import div_pkg::*;
#(
  parameter int BITS           = 16,
  parameter int TIMEOUT_CYCLES = DIV_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  div_request_sequencer_if.slave bus,
  output logic                   busy
);

  div_state_e      state_q, state_d;
  logic [BITS-1:0] dividend_q, dividend_d;
  logic [BITS-1:0] divisor_q, divisor_d;
  logic [BITS-1:0] quotient_q, quotient_d;
  logic            error_q, error_d;
  logic            timeout_q, timeout_d;
  logic            accept;
  logic            expired;

  div_request_sequencer_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q != ST_RUN),
    .inc_i    (state_q == ST_RUN),
    .expired_o(expired)
  );

  // Outputs are gated by reset so they read idle during the reset cycle itself.
  assign bus.in_ready     = reset && (state_q == ST_IDLE);
  assign bus.out_valid    = reset && (state_q == ST_HOLD);
  assign busy             = reset && (state_q != ST_IDLE);
  assign bus.div_reset    = !reset || (state_q == ST_LOAD);
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.out_quotient = quotient_q;
  assign bus.out_error    = error_q;
  assign bus.out_timeout  = timeout_q;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quotient_d = quotient_q;
    error_d    = error_q;
    timeout_d  = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dividend_d = bus.in_dividend;
          divisor_d  = bus.in_divisor;
          if ((bus.in_divisor == '0) || (bus.in_dividend == '0)) begin
            state_d    = ST_HOLD;
            quotient_d = '0;
            error_d    = (bus.in_divisor == '0);
            timeout_d  = 1'b0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        // div_ready is tested first so a completion on the timeout edge wins.
        if (bus.div_ready) begin
          state_d    = ST_HOLD;
          quotient_d = bus.div_result;
          error_d    = 1'b0;
          timeout_d  = 1'b0;
        end else if (expired) begin
          state_d    = ST_HOLD;
          quotient_d = bus.div_result;
          error_d    = 1'b0;
          timeout_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      quotient_q <= '0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quotient_q <= quotient_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_div_request_sequencer.sv
// Scoreboard bench: jobs push expected results, a negedge monitor pops them
// when out_valid appears and checks value, flags, latency and hold stability.
module tb_div_request_sequencer;

  localparam int BITS = 16;

  typedef struct {
    logic [BITS-1:0] q;
    logic            err;
    logic            to;
    int              lat;
    int              acc;
  } exp_t;

  logic clk;
  logic reset;
  logic busy;
  int   cyc;
  int   n_assert;
  int   n_fail;
  int   n_pushed;
  int   n_results;
  int   mode;       // 0: SAR divider model, 1: never ready, 2: ready on 64th RUN cycle

  exp_t exp_q[$];

  div_request_sequencer_if #(.BITS(BITS)) bus ();

  div_request_sequencer #(
    .BITS          (BITS),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Restoring-division divider model, one quotient bit per cycle.
  logic [BITS:0]   m_rem;
  logic [BITS-1:0] m_quo;
  logic [BITS-1:0] m_dd;
  logic [BITS:0]   m_shift;
  int              m_step;
  logic            m_rdy;
  int              run_cnt;

  assign m_shift = {m_rem[BITS-1:0], m_dd[BITS-1]};

  always @(posedge clk) begin
    if (bus.div_reset) begin
      m_rem   <= '0;
      m_quo   <= '0;
      m_dd    <= bus.div_dividend;
      m_step  <= 0;
      m_rdy   <= 1'b0;
      run_cnt <= 0;
    end else begin
      run_cnt <= run_cnt + 1;
      if (!m_rdy) begin
        if (m_shift >= {1'b0, bus.div_divisor}) begin
          m_rem <= m_shift - {1'b0, bus.div_divisor};
          m_quo <= {m_quo[BITS-2:0], 1'b1};
        end else begin
          m_rem <= m_shift;
          m_quo <= {m_quo[BITS-2:0], 1'b0};
        end
        m_dd   <= m_dd << 1;
        m_step <= m_step + 1;
        if (m_step == BITS - 1) m_rdy <= 1'b1;
      end
    end
  end

  assign bus.div_ready  = (mode == 0) ? m_rdy : (mode == 2) ? (run_cnt == 63) : 1'b0;
  assign bus.div_result = (mode == 0) ? m_quo : (mode == 1) ? 16'hABCD : 16'h1234;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: samples on negedge, inputs are driven just after posedge.
  logic holding;
  logic prev_hs;
  logic cur_ok;
  exp_t cur;

  initial begin
    holding = 1'b0;
    prev_hs = 1'b0;
    cur_ok  = 1'b0;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (prev_hs) begin
        check("idle_after_hs in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("idle_after_hs out_valid", {31'd0, bus.out_valid}, 32'd0);
      end
      prev_hs = 1'b0;
      if (bus.out_valid) begin
        if (!holding) begin
          holding = 1'b1;
          if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            cur_ok = 1'b0;
            $display("FAIL unexpected_out_valid: got out_valid=1 quotient %0d, expected no result", bus.out_quotient);
          end else begin
            cur    = exp_q.pop_front();
            cur_ok = 1'b1;
            check("latency", cyc - cur.acc, cur.lat);
            $display("result: quotient=%0d error=%0b timeout=%0b latency=%0d", bus.out_quotient,
                     bus.out_error, bus.out_timeout, cyc - cur.acc);
          end
        end
        if (cur_ok) begin
          check("out_quotient", {16'd0, bus.out_quotient}, {16'd0, cur.q});
          check("out_error", {31'd0, bus.out_error}, {31'd0, cur.err});
          check("out_timeout", {31'd0, bus.out_timeout}, {31'd0, cur.to});
        end
        check("in_ready_during_hold", {31'd0, bus.in_ready}, 32'd0);
        if (bus.out_ready) begin
          holding = 1'b0;
          prev_hs = 1'b1;
          n_results++;
        end
      end
    end else begin
      holding = 1'b0;
      prev_hs = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                      input logic [BITS-1:0] eq, input logic ee, input logic eto,
                      input int lat, input bit push);
    exp_t e;
    int   g;
    step();
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    g = 0;
    while (!bus.in_ready && g < 500) begin
      step();
      g++;
    end
    if (g >= 500) check("send_wait_in_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("job: %0d / %0d", a, b);
    if (push) begin
      e.q   = eq;
      e.err = ee;
      e.to  = eto;
      e.lat = lat;
      e.acc = cyc;
      exp_q.push_back(e);
      n_pushed++;
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && g < 1000) begin
      step();
      g++;
    end
    if (g >= 1000) check("wait_idle_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst out_quotient", {16'd0, bus.out_quotient}, 32'd0);
    check("rst out_error", {31'd0, bus.out_error}, 32'd0);
    check("rst out_timeout", {31'd0, bus.out_timeout}, 32'd0);
    check("rst div_dividend", {16'd0, bus.div_dividend}, 32'd0);
    check("rst div_divisor", {16'd0, bus.div_divisor}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst div_reset", {31'd0, bus.div_reset}, 32'd1);
  endtask

  initial begin
    int g;
    n_assert        = 0;
    n_fail          = 0;
    n_pushed        = 0;
    n_results       = 0;
    mode            = 0;
    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b1;

    repeat (3) step();
    check_reset_values();
    reset = 1'b1;
    step();
    check("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // Real divider path: 2 + 17 RUN cycles.
    send(16'd100, 16'd7, 16'd14, 1'b0, 1'b0, 19, 1'b1);
    wait_idle();

    // Divide by zero bypasses the divider entirely.
    send(16'd50, 16'd0, 16'd0, 1'b1, 1'b0, 1, 1'b1);
    check("zero div_reset hold", {31'd0, bus.div_reset}, 32'd0);
    step();
    check("zero div_reset idle", {31'd0, bus.div_reset}, 32'd0);
    wait_idle();

    // Downstream back-pressure: result must hold for 5 cycles.
    bus.out_ready = 1'b0;
    send(16'd1000, 16'd3, 16'd333, 1'b0, 1'b0, 19, 1'b1);
    g = 0;
    while (!bus.out_valid && g < 200) begin
      step();
      g++;
    end
    if (g >= 200) check("wait_out_valid", {31'd0, bus.out_valid}, 32'd1);
    repeat (5) step();
    bus.out_ready = 1'b1;
    wait_idle();

    // Timeout, then div_ready coinciding with the timeout edge.
    mode = 1;
    send(16'd5, 16'd1, 16'hABCD, 1'b0, 1'b1, 66, 1'b1);
    wait_idle();
    mode = 2;
    send(16'd5, 16'd1, 16'h1234, 1'b0, 1'b0, 66, 1'b1);
    wait_idle();
    mode = 0;

    // Reset in the middle of RUN discards the job.
    send(16'd60000, 16'd1, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) step();
    check("midjob div_dividend", {16'd0, bus.div_dividend}, 32'd60000);
    check("midjob busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    step();
    check_reset_values();
    reset = 1'b1;
    step();
    check("in_ready_after_midjob_reset", {31'd0, bus.in_ready}, 32'd1);
    send(16'd9, 16'd3, 16'd3, 1'b0, 1'b0, 19, 1'b1);
    wait_idle();

    // Back-to-back jobs, including a zero-dividend bypass.
    send(16'd8, 16'd2, 16'd4, 1'b0, 1'b0, 19, 1'b1);
    send(16'd9, 16'd4, 16'd2, 1'b0, 1'b0, 19, 1'b1);
    send(16'd0, 16'd5, 16'd0, 1'b0, 1'b0, 1, 1'b1);
    wait_idle();
    repeat (3) step();

    check("queue_empty", exp_q.size(), 32'd0);
    check("result_count", n_results, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
